psum_acc_drain: RTL and testbench

PSUM_ACC_DRAIN -- requirements
Module: psum_acc_drain

---
 rtl/psum_acc_drain.sv | 135 +++++++++++++
 tb/tb_psum_acc_drain.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_drain.sv
// psum_acc_drain
//   Accumulates signed partial sums from the bottom PE of a column into a
//   small addressed buffer. On request, it drains every entry in address
//   order as a quantized, clamped unsigned activation over a valid/ready
//   handshake.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   Psum_In, Addr_P_In       signed psum and its entry address
//   Valid_P_In, Acc_First    psum strobe; Acc_First overwrites instead of adds
//   Drain_Start, Shift       start a drain; quantization shift latched at start
//   Data_O, Addr_O, Valid_O  drained activation, its index, valid
//   Ready_O                  downstream accept
//   Busy, Done, Err_Drop     draining, end-of-drain pulse, sticky dropped-psum flag
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | accepting psums, waiting for Drain_Start
// DRAIN | presenting entry[r_idx]; advance on Ready_O, psums are dropped
// DONE  | one-cycle Done pulse, psums still dropped, then back to IDLE
module psum_acc_drain #(
  parameter int BIT_PSUM = 32,
  parameter int BIT_ADDR = 4,
  parameter int BIT_ACC  = 40,
  parameter int BIT_DATA = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic signed [BIT_PSUM-1:0] Psum_In,
  input  logic        [BIT_ADDR-1:0] Addr_P_In,
  input  logic                       Valid_P_In,
  input  logic                       Acc_First,
  input  logic                       Drain_Start,
  input  logic        [4:0]          Shift,
  output logic        [BIT_DATA-1:0] Data_O,
  output logic        [BIT_ADDR-1:0] Addr_O,
  output logic                       Valid_O,
  input  logic                       Ready_O,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Err_Drop
);

  localparam int DEPTH = 1 << BIT_ADDR;
  localparam logic signed [BIT_ACC-1:0] DATA_MAX =
    {{(BIT_ACC-BIT_DATA){1'b0}}, {BIT_DATA{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic signed [BIT_ACC-1:0]  r_entry [DEPTH];
  logic        [BIT_ADDR-1:0] r_idx;
  logic        [4:0]          r_shift;
  logic                       r_err_drop;

  logic signed [BIT_ACC-1:0]  w_psum_ext;
  logic signed [BIT_ACC-1:0]  w_sum;
  logic                       w_wr;
  logic                       w_accept;
  logic                       w_last;
  logic signed [BIT_ACC-1:0]  w_rd;
  logic signed [BIT_ACC-1:0]  w_shifted;
  logic        [BIT_DATA-1:0] w_q;

  assign w_psum_ext = {{(BIT_ACC-BIT_PSUM){Psum_In[BIT_PSUM-1]}}, Psum_In};
  // Writes are only honoured in IDLE; the drain reads must see a frozen buffer.
  assign w_wr       = Valid_P_In && (r_state == S_IDLE);
  assign w_sum      = (Acc_First ? '0 : r_entry[Addr_P_In]) + w_psum_ext;
  assign w_accept   = (r_state == S_DRAIN) && Ready_O;
  assign w_last     = (r_idx == {BIT_ADDR{1'b1}});

  // Output data is decoded combinationally from the registered index so that a
  // psum committed on the Drain_Start edge is already visible on the first beat.
  assign w_rd      = r_entry[r_idx];
  assign w_shifted = w_rd >>> r_shift;

  always_comb begin
    w_q = w_shifted[BIT_DATA-1:0];
    if (w_shifted[BIT_ACC-1]) begin
      w_q = '0;
    end else if (w_shifted > DATA_MAX) begin
      w_q = {BIT_DATA{1'b1}};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    Valid_O     = 1'b0;
    Data_O      = '0;
    Addr_O      = '0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Drain_Start) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        Valid_O = 1'b1;
        Data_O  = w_q;
        Addr_O  = r_idx;
        Busy    = 1'b1;
        if (w_accept && w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        Busy        = 1'b1;
        Done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_shift    <= '0;
      r_err_drop <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr) r_entry[Addr_P_In] <= w_sum;
      if ((r_state == S_IDLE) && Drain_Start) begin
        r_shift <= Shift;
        r_idx   <= '0;
      end
      if (w_accept && !w_last) r_idx <= r_idx + 1'b1;
      if (Valid_P_In && (r_state != S_IDLE)) r_err_drop <= 1'b1;
    end
  end

  assign Err_Drop = r_err_drop;

endmodule

// File: tb/tb_psum_acc_drain.sv
// tb_psum_acc_drain
//   Directed bench for psum_acc_drain: reset values, accumulate, quantize,
//   backpressure, simultaneous start/write, drop flag, reset mid-drain, wrap.
module tb_psum_acc_drain;

  logic               CLK = 1'b0;
  logic               RST;
  logic signed [31:0] Psum_In;
  logic        [3:0]  Addr_P_In;
  logic               Valid_P_In;
  logic               Acc_First;
  logic               Drain_Start;
  logic        [4:0]  Shift;
  logic        [7:0]  Data_O;
  logic        [3:0]  Addr_O;
  logic               Valid_O;
  logic               Ready_O;
  logic               Busy;
  logic               Done;
  logic               Err_Drop;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] got_data [16];
  logic [3:0] got_addr [16];
  int         beats;
  int         done_cycle;
  int         last_acc;

  psum_acc_drain dut (
    .CLK(CLK), .RST(RST), .Psum_In(Psum_In), .Addr_P_In(Addr_P_In),
    .Valid_P_In(Valid_P_In), .Acc_First(Acc_First), .Drain_Start(Drain_Start),
    .Shift(Shift), .Data_O(Data_O), .Addr_O(Addr_O), .Valid_O(Valid_O),
    .Ready_O(Ready_O), .Busy(Busy), .Done(Done), .Err_Drop(Err_Drop)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic write_psum(input logic [3:0] a, input logic signed [31:0] p, input logic first);
    Valid_P_In = 1'b1;
    Addr_P_In  = a;
    Psum_In    = p;
    Acc_First  = first;
    tick();
    Valid_P_In = 1'b0;
    Acc_First  = 1'b0;
  endtask

  // Starts a drain with Ready_O held high and records every accepted beat.
  task automatic run_drain(input logic [4:0] sh);
    int cyc;
    bit done_seen;
    Shift       = sh;
    Drain_Start = 1'b1;
    tick();
    Drain_Start = 1'b0;
    Ready_O     = 1'b1;
    beats = 0; done_cycle = -1; last_acc = -100; cyc = 0; done_seen = 0;
    for (int i = 0; i < 16; i++) begin got_data[i] = 'x; got_addr[i] = 'x; end
    while (cyc < 100 && !done_seen) begin
      if (Valid_O) begin
        if (beats < 16) begin got_data[beats] = Data_O; got_addr[beats] = Addr_O; end
        beats++;
        last_acc = cyc;
      end
      if (Done) begin done_seen = 1; done_cycle = cyc; end
      tick();
      cyc++;
    end
    Ready_O = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_assert++; if (Valid_O !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", Valid_O); end
    n_assert++; if (Data_O !== 8'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", Data_O); end
    n_assert++; if (Addr_O !== 4'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", Addr_O); end
    n_assert++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
    n_assert++; if (Done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", Done); end
    n_assert++; if (Err_Drop !== 1'b0) begin n_fail++; $display("FAIL reset_errdrop got %b want 0", Err_Drop); end
  endtask

  task automatic test_accumulate();
    do_reset();
    write_psum(4'd3, 32'sd100, 1'b1);
    write_psum(4'd3, 32'sd50, 1'b0);
    write_psum(4'd3, -32'sd30, 1'b0);
    run_drain(5'd0);
    n_assert++; if (beats !== 16) begin n_fail++; $display("FAIL acc_beats got %0d want 16", beats); end
    for (int i = 0; i < 16; i++) begin
      n_assert++;
      if (got_data[i] !== ((i == 3) ? 8'd120 : 8'd0)) begin
        n_fail++; $display("FAIL acc_data[%0d] got %0d want %0d", i, got_data[i], (i == 3) ? 120 : 0);
      end
    end
    n_assert++; if (done_cycle !== last_acc + 1) begin n_fail++; $display("FAIL acc_done_timing got cycle %0d want %0d", done_cycle, last_acc + 1); end
    n_assert++; if (Done !== 1'b0) begin n_fail++; $display("FAIL acc_done_width got %b want 0", Done); end
    n_assert++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL acc_busy_after got %b want 0", Busy); end
  endtask

  task automatic test_quantize();
    do_reset();
    write_psum(4'd0, 32'sd1000, 1'b1);
    write_psum(4'd1, -32'sd5, 1'b1);
    write_psum(4'd2, 32'sd4095, 1'b1);
    run_drain(5'd4);
    n_assert++; if (got_data[0] !== 8'd62) begin n_fail++; $display("FAIL quant_1000 got %0d want 62", got_data[0]); end
    n_assert++; if (got_data[1] !== 8'd0) begin n_fail++; $display("FAIL quant_neg got %0d want 0", got_data[1]); end
    n_assert++; if (got_data[2] !== 8'd255) begin n_fail++; $display("FAIL quant_4095 got %0d want 255", got_data[2]); end
  endtask

  task automatic test_backpressure();
    int  accepted;
    int  cyc;
    bit  stalled;
    logic [3:0] order [16];
    logic [7:0] data6;
    do_reset();
    write_psum(4'd5, 32'sd77, 1'b1);
    write_psum(4'd6, 32'sd200, 1'b1);
    Shift       = 5'd0;
    Drain_Start = 1'b1;
    tick();
    Drain_Start = 1'b0;
    Shift       = 5'd31;   // latched value must stay 0
    Ready_O     = 1'b1;
    accepted = 0; cyc = 0; stalled = 0; data6 = 'x;
    while (cyc < 100 && !Done) begin
      if (Valid_O && Addr_O == 4'd5 && !stalled) begin
        Ready_O     = 1'b0;
        Drain_Start = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          n_assert++; if (Valid_O !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold got %b want 1", Valid_O); end
          n_assert++; if (Addr_O !== 4'd5) begin n_fail++; $display("FAIL bp_addr_hold got %0d want 5", Addr_O); end
          n_assert++; if (Data_O !== 8'd77) begin n_fail++; $display("FAIL bp_data_hold got %0d want 77", Data_O); end
        end
        Drain_Start = 1'b0;
        Ready_O     = 1'b1;
        stalled     = 1;
      end
      if (Valid_O && Ready_O) begin
        if (accepted < 16) order[accepted] = Addr_O;
        if (Addr_O == 4'd6) data6 = Data_O;
        accepted++;
      end
      tick();
      cyc++;
    end
    Ready_O = 1'b0;
    n_assert++; if (accepted !== 16) begin n_fail++; $display("FAIL bp_beats got %0d want 16", accepted); end
    for (int i = 0; i < 16; i++) begin
      n_assert++;
      if (order[i] !== 4'(i)) begin n_fail++; $display("FAIL bp_order[%0d] got %0d want %0d", i, order[i], i); end
    end
    n_assert++; if (data6 !== 8'd200) begin n_fail++; $display("FAIL bp_shift_latched got %0d want 200", data6); end
    tick();
    tick();
    n_assert++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL bp_start_ignored busy got %b want 0", Busy); end
  endtask

  task automatic test_simultaneous();
    int cyc;
    do_reset();
    Valid_P_In  = 1'b1; Acc_First = 1'b1; Psum_In = 32'sd7; Addr_P_In = 4'd0;
    Drain_Start = 1'b1; Shift = 5'd0;
    tick();
    Valid_P_In = 1'b0; Acc_First = 1'b0; Drain_Start = 1'b0;
    n_assert++; if (Valid_O !== 1'b1) begin n_fail++; $display("FAIL sim_valid got %b want 1", Valid_O); end
    n_assert++; if (Addr_O !== 4'd0) begin n_fail++; $display("FAIL sim_addr got %0d want 0", Addr_O); end
    n_assert++; if (Data_O !== 8'd7) begin n_fail++; $display("FAIL sim_data got %0d want 7", Data_O); end
    n_assert++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL sim_busy got %b want 1", Busy); end
    write_psum(4'd0, 32'sd99, 1'b1);
    n_assert++; if (Err_Drop !== 1'b1) begin n_fail++; $display("FAIL sim_errdrop got %b want 1", Err_Drop); end
    Ready_O = 1'b1;
    cyc = 0;
    while (cyc < 100 && !Done) begin tick(); cyc++; end
    Ready_O = 1'b0;
    n_assert++; if (Done !== 1'b1) begin n_fail++; $display("FAIL sim_drain_timeout done got %b want 1", Done); end
    tick();
    run_drain(5'd0);
    n_assert++; if (got_data[0] !== 8'd7) begin n_fail++; $display("FAIL sim_entry_kept got %0d want 7", got_data[0]); end
    n_assert++; if (Err_Drop !== 1'b1) begin n_fail++; $display("FAIL sim_errdrop_sticky got %b want 1", Err_Drop); end
    do_reset();
    n_assert++; if (Err_Drop !== 1'b0) begin n_fail++; $display("FAIL sim_errdrop_clear got %b want 0", Err_Drop); end
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    int n_done;
    do_reset();
    for (int i = 0; i < 16; i++) write_psum(4'(i), 32'sd10 + 32'(i), 1'b1);
    Shift = 5'd0; Drain_Start = 1'b1;
    tick();
    Drain_Start = 1'b0; Ready_O = 1'b1;
    cyc = 0;
    while (cyc < 50 && !(Valid_O && Addr_O == 4'd6)) begin tick(); cyc++; end
    n_assert++; if (Addr_O !== 4'd6) begin n_fail++; $display("FAIL rmd_reach_beat6 got %0d want 6", Addr_O); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_assert++; if (Valid_O !== 1'b0) begin n_fail++; $display("FAIL rmd_valid got %b want 0", Valid_O); end
    n_assert++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rmd_busy got %b want 0", Busy); end
    n_done = 0;
    for (int k = 0; k < 20; k++) begin if (Done) n_done++; tick(); end
    Ready_O = 1'b0;
    n_assert++; if (n_done !== 0) begin n_fail++; $display("FAIL rmd_no_done got %0d pulses want 0", n_done); end
    run_drain(5'd0);
    n_assert++; if (beats !== 16) begin n_fail++; $display("FAIL rmd_beats got %0d want 16", beats); end
    for (int i = 0; i < 16; i++) begin
      n_assert++;
      if (got_data[i] !== 8'd0) begin n_fail++; $display("FAIL rmd_zero[%0d] got %0d want 0", i, got_data[i]); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    // 256 * (2^31-1) + 255 = 2^39 - 1
    write_psum(4'd9, 32'sh7FFF_FFFF, 1'b1);
    Valid_P_In = 1'b1; Acc_First = 1'b0; Addr_P_In = 4'd9; Psum_In = 32'sh7FFF_FFFF;
    for (int k = 0; k < 255; k++) tick();
    Valid_P_In = 1'b0;
    write_psum(4'd9, 32'sd255, 1'b0);
    run_drain(5'd0);
    n_assert++; if (got_data[9] !== 8'd255) begin n_fail++; $display("FAIL wrap_max got %0d want 255", got_data[9]); end
    write_psum(4'd9, 32'sd1, 1'b0);
    run_drain(5'd0);
    n_assert++; if (got_data[9] !== 8'd0) begin n_fail++; $display("FAIL wrap_neg got %0d want 0", got_data[9]); end
    run_drain(5'd24);
    n_assert++; if (got_data[9] !== 8'd0) begin n_fail++; $display("FAIL wrap_neg_shift got %0d want 0", got_data[9]); end
  endtask

  initial begin
    RST = 1'b1; Psum_In = '0; Addr_P_In = '0; Valid_P_In = 1'b0; Acc_First = 1'b0;
    Drain_Start = 1'b0; Shift = '0; Ready_O = 1'b0;
    test_reset();
    test_accumulate();
    test_quantize();
    test_backpressure();
    test_simultaneous();
    test_reset_mid_drain();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
